// File: rtl/ecr_pkg.sv
// Shared definitions for the ENCRIP 5-bit code stream (encryptor and decryptor).
package ecr_pkg;

    localparam int unsigned DATA_W = 3;
    localparam int unsigned CODE_W = 5;

    localparam logic [CODE_W-1:0] SYNC_WORD_DEF = 5'b11111;
    localparam logic [DATA_W-1:0] KEY_SEED_DEF  = 3'b101;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } ecr_state_t;

    // Code word layout {p1,p0,c[2:0]}: p1 = c2^c1, p0 = c1^c0
    function automatic logic ecr_check(input logic [CODE_W-1:0] code);
        logic [DATA_W-1:0] c;
        c = code[DATA_W-1:0];
        return (code[4] == (c[2] ^ c[1])) && (code[3] == (c[1] ^ c[0]));
    endfunction

    // Period-7 key sequence: 101,011,111,110,100,001,010
    function automatic logic [DATA_W-1:0] key_next(input logic [DATA_W-1:0] k);
        return {k[1:0], k[2] ^ k[1]};
    endfunction

endpackage

// File: rtl/ecr_key_lfsr.sv
// Rolling key register: reseeds on reset or load, otherwise advances on step.
module ecr_key_lfsr
    import ecr_pkg::*;
#(
    parameter logic [DATA_W-1:0] SEED = KEY_SEED_DEF
)(
    input  logic              clk,
    input  logic              RST,
    input  logic              load,
    input  logic              step,
    output logic [DATA_W-1:0] key
);

    // Reseed has priority over stepping
    always_ff @(posedge clk) begin
        if (RST || load) begin
            key <= SEED;
        end else if (step) begin
            key <= key_next(key);
        end
    end

endmodule

// File: rtl/ecr_decrypt.sv
// Receive-side ENCRIP stage: sync-word lock, check-bit verification, key removal.
module ecr_decrypt
    import ecr_pkg::*;
#(
    parameter logic [DATA_W-1:0] KEY_SEED  = KEY_SEED_DEF,
    parameter logic [CODE_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int unsigned       MAX_ERR   = 3,
    parameter int unsigned       ERR_W     = 8
)(
    input  logic              clk,
    input  logic              RST,
    input  logic [CODE_W-1:0] ECRi,
    input  logic              ECRi_valid,
    output logic [DATA_W-1:0] Dout,
    output logic              Dout_valid,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              locked
);

    localparam int unsigned       CONS_W    = $clog2(MAX_ERR + 1);
    localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(MAX_ERR - 1);

    ecr_state_t        state;
    logic [CONS_W-1:0] consec;
    logic [DATA_W-1:0] key;

    logic is_sync;
    logic chk_ok;
    logic word_good;
    logic word_bad;
    logic sync_seen;
    logic drop_lock;
    logic key_load;
    logic key_step;

    // Classify the incoming word and derive key control
    always_comb begin
        is_sync   = (ECRi == SYNC_WORD);
        chk_ok    = ecr_check(ECRi);
        sync_seen = ECRi_valid && is_sync;
        word_good = ECRi_valid && (state == LOCK) && !is_sync && chk_ok;
        word_bad  = ECRi_valid && (state == LOCK) && !is_sync && !chk_ok;
        drop_lock = word_bad && (consec == CONS_LAST);
        // A failed word still advances the key so a single hit keeps alignment
        key_load  = sync_seen || drop_lock;
        key_step  = word_good || word_bad;
    end

    ecr_key_lfsr #(
        .SEED (KEY_SEED)
    ) u_key (
        .clk  (clk),
        .RST  (RST),
        .load (key_load),
        .step (key_step),
        .key  (key)
    );

    // Lock FSM, consecutive-error tracking and registered outputs
    always_ff @(posedge clk) begin
        if (RST) begin
            state      <= HUNT;
            consec     <= '0;
            Dout       <= '0;
            Dout_valid <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            locked     <= 1'b0;
        end else begin
            Dout_valid <= word_good;
            err        <= word_bad;
            if (word_good) begin
                Dout <= ECRi[DATA_W-1:0] ^ key;
            end
            if (word_bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (sync_seen) begin
                state  <= LOCK;
                locked <= 1'b1;
                consec <= '0;
            end else if (drop_lock) begin
                state  <= HUNT;
                locked <= 1'b0;
                consec <= '0;
            end else if (word_bad) begin
                consec <= consec + 1'b1;
            end else if (word_good) begin
                consec <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ecr_decrypt.sv
// Self-checking bench for ecr_decrypt: directed scenarios plus randomized traffic.
module tb_ecr_decrypt;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [4:0] ECRi = '0;
    logic       ECRi_valid = 1'b0;

    logic [2:0] dout_a, dout_b;
    logic       dv_a, dv_b, err_a, err_b, lk_a, lk_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int tests = 0;
    int fails = 0;

    // reference model state
    int keys [7] = '{5, 3, 7, 6, 4, 1, 2};
    int m_locked, m_kidx, m_consec, m_errs, m_dout, m_dv, m_err;

    always #5 clk = ~clk;

    ecr_decrypt #(.ERR_W(8)) u_dut (
        .clk(clk), .RST(RST), .ECRi(ECRi), .ECRi_valid(ECRi_valid),
        .Dout(dout_a), .Dout_valid(dv_a), .err(err_a), .err_cnt(cnt_a), .locked(lk_a)
    );

    ecr_decrypt #(.ERR_W(2)) u_sat (
        .clk(clk), .RST(RST), .ECRi(ECRi), .ECRi_valid(ECRi_valid),
        .Dout(dout_b), .Dout_valid(dv_b), .err(err_b), .err_cnt(cnt_b), .locked(lk_b)
    );

    function automatic int bit_of(input int v, input int n);
        return (v >> n) & 1;
    endfunction

    function automatic logic [4:0] encode(input int data, input int key);
        int c;
        c = (data ^ key) & 7;
        return 5'((((bit_of(c, 2) ^ bit_of(c, 1)) << 4) | ((bit_of(c, 1) ^ bit_of(c, 0)) << 3) | c));
    endfunction

    task automatic model(input logic r, input logic v, input logic [4:0] code);
        int c, ok;
        if (r) begin
            m_locked = 0; m_kidx = 0; m_consec = 0; m_errs = 0;
            m_dout = 0; m_dv = 0; m_err = 0;
            return;
        end
        m_dv = 0; m_err = 0;
        if (!v) return;
        if (code == 5'd31) begin
            m_locked = 1; m_kidx = 0; m_consec = 0;
        end else if (m_locked != 0) begin
            c  = int'(code) & 7;
            ok = (bit_of(int'(code), 4) == (bit_of(c, 2) ^ bit_of(c, 1))) &&
                 (bit_of(int'(code), 3) == (bit_of(c, 1) ^ bit_of(c, 0)));
            m_kidx = (m_kidx + 1) % 7;
            if (ok != 0) begin
                m_dout = c ^ keys[(m_kidx + 6) % 7];
                m_dv = 1; m_consec = 0;
            end else begin
                m_err = 1; m_errs++; m_consec++;
                if (m_consec == 3) begin
                    m_locked = 0; m_kidx = 0; m_consec = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [4:0] code);
        RST = r; ECRi_valid = v; ECRi = code;
        model(r, v, code);
        @(posedge clk);
        #1;
        chk("dout",      int'(dout_a), m_dout);
        chk("dout_valid", int'(dv_a),  m_dv);
        chk("err",       int'(err_a),  m_err);
        chk("err_cnt8",  int'(cnt_a),  (m_errs > 255) ? 255 : m_errs);
        chk("locked",    int'(lk_a),   m_locked);
        chk("err_cnt2",  int'(cnt_b),  (m_errs > 3) ? 3 : m_errs);
        chk("sat_dout",  int'({dout_b, dv_b, err_b, lk_b}), int'({dout_a, dv_a, err_a, lk_a}));
        RST = 1'b0; ECRi_valid = 1'b0;
    endtask

    initial begin
        int sel, data;
        logic [4:0] w;

        // 1: reset then idle
        step(1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 5'd31);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 5'd0);

        // 2: lock and decode two words
        step(1'b0, 1'b1, 5'b11111);
        chk("t2_locked", int'(lk_a), 1);
        step(1'b0, 1'b1, 5'b10100);
        chk("t2_d0", int'(dout_a), 1);
        chk("t2_v0", int'(dv_a), 1);
        step(1'b0, 1'b1, 5'b01001);
        chk("t2_d1", int'(dout_a), 2);
        step(1'b0, 1'b0, 5'b01001);
        chk("t2_hold", int'(dout_a), 2);

        // 3: single corrupted word keeps alignment
        step(1'b0, 1'b1, 5'b11111);
        step(1'b0, 1'b1, 5'b10101);
        chk("t3_err", int'(err_a), 1);
        chk("t3_cnt", int'(cnt_a), 1);
        step(1'b0, 1'b1, 5'b01001);
        chk("t3_d", int'(dout_a), 2);

        // 4: three consecutive failures drop lock
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b00000 ^ 5'b10000);
        step(1'b0, 1'b1, 5'b10101);
        chk("t4_unlocked", int'(lk_a), 0);
        step(1'b0, 1'b1, 5'b10100);
        chk("t4_ignored", int'(dv_a), 0);
        step(1'b0, 1'b1, 5'b11111);
        step(1'b0, 1'b1, 5'b10100);
        chk("t4_relock_d", int'(dout_a), 1);

        // 5: resync mid-stream
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, encode(i + 3, keys[m_kidx]));
        step(1'b0, 1'b1, 5'b11111);
        chk("t5_no_dv", int'(dv_a), 0);
        step(1'b0, 1'b1, 5'b10100);
        chk("t5_d", int'(dout_a), 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            sel  = int'($urandom_range(0, 9));
            data = int'($urandom_range(0, 7));
            w    = encode(data, keys[m_kidx]);
            if (sel == 0)      w = 5'b11111;
            else if (sel == 1) w = w ^ 5'b10000;
            else if (sel == 2) w = w ^ 5'b01000;
            else if (sel == 3) w = 5'($urandom_range(0, 31));
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, w);
        end

        // 6: saturation on the 2-bit counter, then reset colliding with a valid word
        step(1'b1, 1'b0, 5'd0);
        step(1'b0, 1'b1, 5'b11111);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b11111);
        step(1'b0, 1'b1, 5'b10101);
        step(1'b0, 1'b1, 5'b10101);
        chk("t6_sat2", int'(cnt_b), 3);
        chk("t6_cnt8", int'(cnt_a), 4);
        step(1'b1, 1'b1, 5'b11111);
        chk("t6_rst_lock", int'(lk_a), 0);
        chk("t6_rst_cnt", int'(cnt_b), 0);
        step(1'b0, 1'b1, 5'b10100);
        chk("t6_no_decode", int'(dv_a), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
